// File: rtl/mul_pkg.sv
// Shared constants, geometry helpers and stage payload layout for the pipelined array multiplier.
package mul_pkg;

    localparam logic SGN_UNSIGNED = 1'b0;
    localparam logic SGN_SIGNED   = 1'b1;
    localparam int   MAX_WIDTH    = 32;

    // Widest payload layout; each stage keeps a WIDTH-sized copy with the same field order.
    typedef struct packed {
        logic                   valid;
        logic                   sgn;
        logic [2*MAX_WIDTH-1:0] acc;
        logic [2*MAX_WIDTH-1:0] xe;
        logic [MAX_WIDTH-1:0]   yrem;
    } mul_stage_t;

    function automatic int rows_per_stage(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int stage_first_row(input int width, input int stages, input int s);
        return s * rows_per_stage(width, stages);
    endfunction

    // Trailing stages can end up with no rows when STAGES does not divide WIDTH evenly.
    function automatic int stage_num_rows(input int width, input int stages, input int s);
        int lo;
        int hi;
        lo = s * rows_per_stage(width, stages);
        hi = (s + 1) * rows_per_stage(width, stages);
        if (hi > width) hi = width;
        return (hi > lo) ? (hi - lo) : 0;
    endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// One pipeline stage: folds partial-product rows [FIRST_ROW, FIRST_ROW+NUM_ROWS) into the
// running sum and registers the payload when enabled.
module mul_pp_stage
    import mul_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int FIRST_ROW = 0,
    parameter int NUM_ROWS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_valid,
    input  logic               i_sgn,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_xe,
    input  logic [WIDTH-1:0]   i_yrem,
    output logic               o_valid,
    output logic               o_sgn,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_xe,
    output logic [WIDTH-1:0]   o_yrem
);

    typedef struct packed {
        logic               valid;
        logic               sgn;
        logic [2*WIDTH-1:0] acc;
        logic [2*WIDTH-1:0] xe;
        logic [WIDTH-1:0]   yrem;
    } stage_t;

    localparam logic [63:0]      ROW_MASK64 = ((64'd1 << NUM_ROWS) - 64'd1) << FIRST_ROW;
    localparam logic [WIDTH-1:0] ROW_MASK   = ROW_MASK64[WIDTH-1:0];

    logic [2*WIDTH-1:0] w_acc_n;
    stage_t             r_q;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        localparam int ROW = FIRST_ROW + r;
        logic [2*WIDTH-1:0] w_in;
        logic [2*WIDTH-1:0] w_pp;
        logic [2*WIDTH-1:0] w_out;

        if (r == 0) begin : g_first
            assign w_in = i_acc;
        end else begin : g_next
            assign w_in = g_row[r-1].w_out;
        end

        assign w_pp = i_yrem[ROW] ? (i_xe << ROW) : '0;

        // The multiplier MSB carries weight -2^(W-1) in two's complement.
        if (ROW == WIDTH - 1) begin : g_msb
            assign w_out = (i_sgn == SGN_SIGNED) ? (w_in - w_pp) : (w_in + w_pp);
        end else begin : g_mid
            assign w_out = w_in + w_pp;
        end
    end

    if (NUM_ROWS == 0) begin : g_pass
        assign w_acc_n = i_acc;
    end else begin : g_sum
        assign w_acc_n = g_row[NUM_ROWS-1].w_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= '{valid: i_valid, sgn: i_sgn, acc: w_acc_n, xe: i_xe,
                     yrem: i_yrem & ~ROW_MASK};
        end
    end

    assign o_valid = r_q.valid;
    assign o_sgn   = r_q.sgn;
    assign o_acc   = r_q.acc;
    assign o_xe    = r_q.xe;
    assign o_yrem  = r_q.yrem;

endmodule

// File: rtl/mul_array_pipe.sv
// Pipelined WIDTH x WIDTH array multiplier, unsigned or two's-complement per transaction,
// with valid/ready on both sides and a single global advance for backpressure.
module mul_array_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    // Index 0 is the incoming transaction; index s+1 is the register of stage s.
    logic [STAGES:0]              w_vld_pipe;
    logic [STAGES:0]              w_sgn;
    logic [STAGES:0][2*WIDTH-1:0] w_acc;
    logic [STAGES:0][2*WIDTH-1:0] w_xe;
    logic [STAGES:0][WIDTH-1:0]   w_yrem;
    logic                         w_adv;
    logic                         w_unused;

    // Whole chain moves or holds together; bubbles are kept, so the only stall is the tail.
    assign w_adv    = !w_vld_pipe[STAGES] || out_ready;
    assign in_ready = w_adv;

    assign w_vld_pipe[0] = in_valid;
    assign w_sgn[0]      = sgn;
    assign w_acc[0]      = '0;
    assign w_xe[0]       = (sgn == SGN_SIGNED) ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    assign w_yrem[0]     = y;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        mul_pp_stage #(
            .WIDTH     (WIDTH),
            .FIRST_ROW (stage_first_row(WIDTH, STAGES, s)),
            .NUM_ROWS  (stage_num_rows(WIDTH, STAGES, s))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_adv),
            .i_valid (w_vld_pipe[s]),
            .i_sgn   (w_sgn[s]),
            .i_acc   (w_acc[s]),
            .i_xe    (w_xe[s]),
            .i_yrem  (w_yrem[s]),
            .o_valid (w_vld_pipe[s+1]),
            .o_sgn   (w_sgn[s+1]),
            .o_acc   (w_acc[s+1]),
            .o_xe    (w_xe[s+1]),
            .o_yrem  (w_yrem[s+1])
        );
    end

    assign out_valid = w_vld_pipe[STAGES];
    assign out       = w_acc[STAGES];

    // The tail stage's operand copies have no consumer.
    assign w_unused = ^{w_sgn[STAGES], w_xe[STAGES], w_yrem[STAGES]};

endmodule

// File: tb/tb_mul_array_pipe.sv
// Directed vectors and handshake corner cases on a 4x4/2-stage instance, plus random
// scoreboarded sweeps over several WIDTH/STAGES geometries.
module tb_mul_array_pipe;

    logic clk;
    int   n_pass  = 0;
    int   n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        logic [63:0] m;
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        m  = (64'd1 << w) - 64'd1;
        xa = {32'd0, a} & m;
        xb = {32'd0, b} & m;
        if (s && xa[w-1]) xa = xa | ~m;
        if (s && xb[w-1]) xb = xb | ~m;
        p = xa * xb;
        if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    // ---------------- main 4x4, 2-stage instance ----------------
    logic       m_rst, m_iv, m_irdy, m_sgn, m_ov, m_ordy;
    logic [3:0] m_x, m_y;
    logic [7:0] m_out;

    mul_array_pipe #(.WIDTH(4), .STAGES(2)) u_dut (
        .clk(clk), .rst(m_rst), .in_valid(m_iv), .in_ready(m_irdy), .x(m_x), .y(m_y),
        .sgn(m_sgn), .out_valid(m_ov), .out_ready(m_ordy), .out(m_out)
    );

    // ---------------- random sweep instances ----------------
    localparam int NSW = 9;
    logic           rst_sw;
    logic [NSW-1:0] sw_done;

    function automatic int sw_width(input int g);
        case (g / 3)
            0:       return 4;
            1:       return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int sw_stages(input int g);
        case (g % 3)
            0:       return 1;
            1:       return 3;
            default: return sw_width(g);
        endcase
    endfunction

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W = sw_width(g);
        localparam int S = sw_stages(g);
        logic [W-1:0]   sx, sy;
        logic           ssgn, siv, sirdy, sov, sordy, done;
        logic [2*W-1:0] sout;

        mul_array_pipe #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk(clk), .rst(rst_sw), .in_valid(siv), .in_ready(sirdy), .x(sx), .y(sy),
            .sgn(ssgn), .out_valid(sov), .out_ready(sordy), .out(sout)
        );
        assign sw_done[g] = done;

        initial begin
            logic [63:0] q_exp[$];
            int          q_cyc[$];
            logic [63:0] e;
            int          c;
            int          last_stall;
            logic        pend;
            done = 1'b0; siv = 1'b0; sordy = 1'b0; sx = '0; sy = '0; ssgn = 1'b0;
            pend = 1'b0; last_stall = -1;
            repeat (5) @(negedge clk);
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (!pend && k < 300 && $urandom_range(0, 3) != 0) begin
                    sx   = W'($urandom);
                    sy   = W'($urandom);
                    ssgn = 1'($urandom);
                    pend = 1'b1;
                end
                siv   = pend;
                sordy = (k >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (!sordy) last_stall = k;
                #1;
                if (sov && sordy) begin
                    if (q_exp.size() == 0) begin
                        chk("sw_spurious_out", 64'(sov), 64'd0);
                    end else begin
                        e = q_exp.pop_front();
                        c = q_cyc.pop_front();
                        chk("sw_product", 64'(sout), e);
                        if (last_stall < c) chk("sw_latency", 64'(k - c), 64'(S));
                    end
                end
                if (siv && sirdy) begin
                    q_exp.push_back(model(W, 32'(sx), 32'(sy), ssgn));
                    q_cyc.push_back(k);
                    pend = 1'b0;
                end
            end
            chk("sw_drained", 64'(q_exp.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequences ----------------
    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       sgn;
        logic [7:0] p;
    } vec_t;

    localparam int NV = 12;
    vec_t       vec [NV];
    logic [7:0] bp_exp [6];

    initial begin
        int bp_in, bp_out, stall;
        logic seen;

        vec[0]  = '{4'h4, 4'h8, 1'b0, 8'h20};
        vec[1]  = '{4'h5, 4'h3, 1'b0, 8'h0F};
        vec[2]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vec[3]  = '{4'h0, 4'hF, 1'b0, 8'h00};
        vec[4]  = '{4'h8, 4'h8, 1'b1, 8'h40};
        vec[5]  = '{4'hF, 4'h7, 1'b1, 8'hF9};
        vec[6]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vec[7]  = '{4'hF, 4'hF, 1'b1, 8'h01};
        vec[8]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vec[9]  = '{4'h8, 4'hF, 1'b0, 8'h78};
        vec[10] = '{4'h7, 4'h8, 1'b1, 8'hC8};
        vec[11] = '{4'h8, 4'h1, 1'b1, 8'hF8};
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h0C; bp_exp[2] = 8'h1E;
        bp_exp[3] = 8'h38; bp_exp[4] = 8'h5A; bp_exp[5] = 8'h84;

        m_rst = 1'b1; rst_sw = 1'b1;
        m_iv = 1'b0; m_x = '0; m_y = '0; m_sgn = 1'b0; m_ordy = 1'b0;
        repeat (3) @(negedge clk);
        m_rst = 1'b0; rst_sw = 1'b0;
        #1;
        chk("reset_out_valid", 64'(m_ov), 64'd0);
        chk("reset_out", 64'(m_out), 64'd0);
        chk("reset_in_ready", 64'(m_irdy), 64'd1);

        // Back-to-back table stream with out_ready held high: item k appears 2 cycles later.
        m_ordy = 1'b1;
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k < NV) begin
                m_iv = 1'b1; m_x = vec[k].x; m_y = vec[k].y; m_sgn = vec[k].sgn;
            end else begin
                m_iv = 1'b0;
            end
            #1;
            if (k < NV) chk("tbl_in_ready", 64'(m_irdy), 64'd1);
            if (k < 2) begin
                chk("tbl_latency_idle", 64'(m_ov), 64'd0);
            end else begin
                chk("tbl_out_valid", 64'(m_ov), 64'd1);
                chk("tbl_product", 64'(m_out), 64'(vec[k-2].p));
            end
        end
        @(negedge clk); #1;
        chk("tbl_drained", 64'(m_ov), 64'd0);

        // Six items with a 3-cycle consumer stall right after the first result appears.
        bp_in = 0; bp_out = 0; stall = 0; seen = 1'b0;
        for (int k = 0; k < 40 && bp_out < 6; k++) begin
            @(negedge clk);
            m_iv = (bp_in < 6);
            if (bp_in < 6) begin
                m_x = 4'(2 * bp_in + 1); m_y = 4'(2 * bp_in + 2); m_sgn = 1'b0;
            end
            #1;
            if (m_ov && !seen) begin
                seen = 1'b1; stall = 3;
            end
            m_ordy = (stall == 0);
            #1;
            if (stall > 0) begin
                chk("bp_in_ready_low", 64'(m_irdy), 64'd0);
                chk("bp_out_stable", 64'(m_out), 64'(bp_exp[bp_out]));
                stall--;
            end
            if (m_ov && m_ordy) begin
                chk("bp_product", 64'(m_out), 64'(bp_exp[bp_out]));
                bp_out++;
            end
            if (m_iv && m_irdy) bp_in++;
        end
        chk("bp_count", 64'(bp_out), 64'd6);
        m_iv = 1'b0; m_ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("bp_no_duplicate", 64'(m_ov), 64'd0);
        end

        // Reset with two products in flight.
        @(negedge clk);
        m_iv = 1'b1; m_x = 4'h3; m_y = 4'h3; m_sgn = 1'b0; m_ordy = 1'b0;
        @(negedge clk);
        m_x = 4'h5; m_y = 4'h7;
        @(negedge clk);
        m_iv = 1'b0; m_rst = 1'b1;
        #1;
        chk("rst_item_in_flight", 64'(m_ov), 64'd1);
        @(negedge clk);
        m_rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(m_ov), 64'd0);
        chk("rst_out", 64'(m_out), 64'd0);
        chk("rst_in_ready", 64'(m_irdy), 64'd1);
        m_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_no_stale", 64'(m_ov), 64'd0);
        end

        for (int t = 0; t < 5000 && sw_done != {NSW{1'b1}}; t++) @(negedge clk);
        chk("sweep_finished", 64'(sw_done), 64'((1 << NSW) - 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
